// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add sequencer.
// The nbits saturation helper is shared by the sequencer and any sibling command logic.
package serial_add_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRead,
        StSum,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned LanesDef   = 32;
    localparam int unsigned AddrWDef   = 8;
    localparam int unsigned MaxBitsDef = 32;
    localparam int unsigned NbWDef     = 6;

    function automatic int unsigned sat_nbits(input int unsigned nbits,
                                              input int unsigned max_bits);
        return (nbits > max_bits) ? max_bits : nbits;
    endfunction

endpackage

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: walks operand bit-planes LSB-first, requests dual-row sensing,
// steers the sibling serial_add carry register and writes each sum plane back to the array.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned LANES    = LanesDef,
    parameter int unsigned ADDR_W   = AddrWDef,
    parameter int unsigned MAX_BITS = MaxBitsDef,
    parameter int unsigned NB_W     = NbWDef
) (
    input  logic              sys_clk_in,
    input  logic              sys_reset_n_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [ADDR_W-1:0] cmd_a_base_in,
    input  logic [ADDR_W-1:0] cmd_b_base_in,
    input  logic [ADDR_W-1:0] cmd_d_base_in,
    input  logic [NB_W-1:0]   cmd_nbits_in,
    input  logic [LANES-1:0]  cmd_cin_in,
    output logic              rd_req_out,
    output logic [ADDR_W-1:0] rd_addr_a_out,
    output logic [ADDR_W-1:0] rd_addr_b_out,
    input  logic              rd_ack_in,
    input  logic [LANES-1:0]  and_plane_in,
    input  logic [LANES-1:0]  xor_plane_in,
    output logic [LANES-1:0]  and_out,
    output logic [LANES-1:0]  xor_out,
    output logic [LANES-1:0]  carry_out,
    output logic              load_carry_out,
    output logic              update_carry_out,
    input  logic [LANES-1:0]  sum_in,
    output logic              wr_req_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [LANES-1:0]  wr_data_out,
    input  logic              wr_ack_in,
    output logic              busy_out,
    output logic              done_out
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W-1:0] d_base_q, d_base_d;
    logic [NB_W-1:0]   nbits_q, nbits_d;
    logic [NB_W-1:0]   bit_q, bit_d;
    logic [LANES-1:0]  cin_q, cin_d;
    logic [LANES-1:0]  and_q, and_d;
    logic [LANES-1:0]  xor_q, xor_d;
    logic [LANES-1:0]  wr_data_q, wr_data_d;

    logic              cmd_accept;
    logic              last_bit;
    logic [NB_W-1:0]   nbits_sat;

    assign cmd_accept = cmd_valid_in && (state_q == StIdle);
    assign nbits_sat  = NB_W'(sat_nbits(32'(cmd_nbits_in), MAX_BITS));
    // nbits_q is never zero outside IDLE/DONE, so the subtraction cannot underflow in WRITE.
    assign last_bit   = (bit_q == (nbits_q - NB_W'(1)));

    // State register
    always_ff @(posedge sys_clk_in or negedge sys_reset_n_in) begin
        if (!sys_reset_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_in) begin
                    state_d = (nbits_sat == '0) ? StDone : StLoad;
                end
            end
            StLoad:  state_d = StRead;
            StRead:  if (rd_ack_in) state_d = StSum;
            StSum:   state_d = StWrite;
            StWrite: if (wr_ack_in) state_d = last_bit ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready_out    = (state_q == StIdle);
        busy_out         = (state_q != StIdle);
        load_carry_out   = (state_q == StLoad);
        rd_req_out       = (state_q == StRead);
        update_carry_out = (state_q == StSum);
        wr_req_out       = (state_q == StWrite);
        done_out         = (state_q == StDone);
        rd_addr_a_out    = a_base_q + ADDR_W'(bit_q);
        rd_addr_b_out    = b_base_q + ADDR_W'(bit_q);
        wr_addr_out      = d_base_q + ADDR_W'(bit_q);
        and_out          = and_q;
        xor_out          = xor_q;
        carry_out        = cin_q;
        wr_data_out      = wr_data_q;
    end

    // Datapath next-state
    always_comb begin
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        d_base_d  = d_base_q;
        nbits_d   = nbits_q;
        bit_d     = bit_q;
        cin_d     = cin_q;
        and_d     = and_q;
        xor_d     = xor_q;
        wr_data_d = wr_data_q;

        if (cmd_accept) begin
            a_base_d = cmd_a_base_in;
            b_base_d = cmd_b_base_in;
            d_base_d = cmd_d_base_in;
            nbits_d  = nbits_sat;
            cin_d    = cmd_cin_in;
            bit_d    = '0;
        end
        if ((state_q == StRead) && rd_ack_in) begin
            and_d = and_plane_in;
            xor_d = xor_plane_in;
        end
        // serial_add's carry updates on this same edge, so sum_in still reflects the old carry.
        if (state_q == StSum) begin
            wr_data_d = sum_in;
        end
        if ((state_q == StWrite) && wr_ack_in && !last_bit) begin
            bit_d = bit_q + NB_W'(1);
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_reset_n_in) begin
        if (!sys_reset_n_in) begin
            a_base_q  <= '0;
            b_base_q  <= '0;
            d_base_q  <= '0;
            nbits_q   <= '0;
            bit_q     <= '0;
            cin_q     <= '0;
            and_q     <= '0;
            xor_q     <= '0;
            wr_data_q <= '0;
        end else begin
            a_base_q  <= a_base_d;
            b_base_q  <= b_base_d;
            d_base_q  <= d_base_d;
            nbits_q   <= nbits_d;
            bit_q     <= bit_d;
            cin_q     <= cin_d;
            and_q     <= and_d;
            xor_q     <= xor_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Bit-serial add sequencer for the compute-in-memory column array. It sits between the command source and the array/serial_add datapath. It steps LSB-first through the bit-planes of operands A and B, requests dual-row sensing, and registers the sensed AND/XOR planes. It then drives serial_add's carry controls and writes each sum bit-plane back to the destination rows.

Parameters:
LANES, 32, number of bit-serial columns (width of all plane buses)
ADDR_W, 8, array row address width
MAX_BITS, 32, maximum operand width in bits
NB_W, 6, width of nbits field; must be at least clog2(MAX_BITS+1)

Ports:
sys_clk_in  input  1  system clock, all logic on rising edge
sys_reset_n_in  input  1  asynchronous active-low reset
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  high only in IDLE
cmd_a_base_in  input  ADDR_W  row holding bit 0 of A
cmd_b_base_in  input  ADDR_W  row holding bit 0 of B
cmd_d_base_in  input  ADDR_W  row receiving bit 0 of sum
cmd_nbits_in  input  NB_W  operand width in bits
cmd_cin_in  input  LANES  initial carry per lane (all ones for subtract)
rd_req_out  output  1  dual-row sense request
rd_addr_a_out  output  ADDR_W  A row = a_base + bit
rd_addr_b_out  output  ADDR_W  B row = b_base + bit
rd_ack_in  input  1  sense complete; and_plane_in/xor_plane_in valid this cycle
and_plane_in  input  LANES  sensed A&B
xor_plane_in  input  LANES  sensed A^B
and_out  output  LANES  registered AND plane to serial_add and_in
xor_out  output  LANES  registered XOR plane to serial_add xor_in
carry_out  output  LANES  to serial_add carry_in (= latched cmd_cin)
load_carry_out  output  1  one-cycle pulse in LOAD
update_carry_out  output  1  one-cycle pulse in SUM
sum_in  input  LANES  from serial_add sum_out
wr_req_out  output  1  writeback request
wr_addr_out  output  ADDR_W  d_base + bit
wr_data_out  output  LANES  captured sum plane
wr_ack_in  input  1  write accepted this cycle
busy_out  output  1  high when not IDLE
done_out  output  1  one-cycle pulse at completion

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0 except cmd_ready_out=1.
  - All internal registers are 0.
  - An outstanding request is abandoned; no completion pulse is issued.
- States: IDLE, LOAD, READ, SUM, WRITE, DONE.
- IDLE:
  - Command accepted on an edge where cmd_valid_in and cmd_ready_out are both high.
  - Latch bases, cmd_cin_in and nbits; reset the bit counter to 0.
  - nbits > MAX_BITS saturates to MAX_BITS.
  - nbits == 0 goes directly to DONE with no array or carry activity.
  - Otherwise go to LOAD.
- LOAD: load_carry_out=1 with carry_out = latched cin for one cycle, then READ.
- READ:
  - rd_req_out=1 with rd_addr_a_out and rd_addr_b_out held stable until rd_ack_in.
  - On the ack edge, register and_plane_in/xor_plane_in into and_out/xor_out and go to SUM.
  - and_out/xor_out hold until the next read ack.
- SUM:
  - update_carry_out=1 for one cycle.
  - Capture sum_in into wr_data_out on the same edge; the carry register updates from the pre-edge carry, so the sum is consistent.
  - Then WRITE.
- WRITE:
  - wr_req_out=1 with addr/data stable until wr_ack_in.
  - On ack: if bit == nbits-1 go to DONE, else bit+1 and READ.
- DONE: done_out=1 for one cycle, then IDLE.
- Acks: rd_ack_in/wr_ack_in are ignored outside READ/WRITE respectively.
- Latency: with same-cycle acks, an N-bit add takes 3 cycles per bit. done_out is high in cycle 3N+2 after the accept edge (cycle 0 = accept). nbits == 0 gives done_out in cycle 1.
- Address arithmetic is modulo 2^ADDR_W; base + bit wraps silently.
- cmd_valid_in is ignored while busy; no queuing.
- The carry-out of the final bit remains in serial_add's register; this block does not read it.

Decomposition:
- Package serial_add_pkg: state enum type, LANES/ADDR_W/MAX_BITS defaults, nbits saturation function.
- No sub-module: a single FSM plus datapath registers. serial_add stays a separate sibling instance connected at the top level.

Test Plan:
- Reset and idle: reset, release, hold idle -> cmd_ready_out=1, busy_out=0, no rd_req/wr_req/load/update pulses.
- 4-bit add with zero-latency acks:
  - Stimulus: lane0 A=5, B=3, cin=0; a_base=0x10, b_base=0x20, d_base=0x30.
  - Required: writes to 0x30..0x33 give lane0 bits 0,0,0,1 (sum 8).
  - Required: done_out in cycle 14.
- 4-bit subtract: lane1 A=9, B=~2=13 (4-bit), cin lane1=1 -> written lane1 value 7; other lanes with cin=0 compute plain A+B.
- Backpressure: rd_ack_in delayed 3 cycles and wr_ack_in delayed 2 cycles per bit -> addresses/data stay stable while waiting, no extra update pulses, result unchanged.
- Boundaries:
  - nbits=0 -> done_out in cycle 1 with no requests.
  - nbits=40 -> exactly 32 writes.
  - d_base=0xFE, nbits=4 -> write addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation: assert reset during the WRITE of bit 2 -> outputs zero immediately, no done_out; a new command afterwards completes correctly.
